cpu_rmw_sequencer: RTL

- Multi-cycle controller for 6502 memory read-modify-write instructions: ASL, LSR, ROL, ROR, INC and DEC on a memory operand.
- Reads the operand over a req/ack memory port and drives the shared combinational ALU.
- Writes back the unmodified value, then the result, matching 6502 bus behaviour; the first write is optional via a parameter.
- Publishes N/Z/C flag updates for the status register.
- Sits between the instruction decoder and the memory/ALU datapath; the decoder hands off one RMW operation at a time.

---
 rtl/cpu_rmw_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/cpu_rmw_sequencer.sv
// 6502 read-modify-write sequencer: reads a memory operand, drives the shared ALU,
// writes back the old value (optional) and then the result, and reports N/Z/C.
module cpu_rmw_sequencer #(
    parameter int ADDR_W      = 16,
    parameter int DUMMY_WRITE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic              carry_in,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_req,
    input  logic              mem_rd_ack,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr_req,
    input  logic              mem_wr_ack,
    output logic [7:0]        mem_wdata,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_b,
    output logic [3:0]        alu_op,
    output logic              alu_cin,
    input  logic [7:0]        alu_result,
    input  logic              alu_carry,
    input  logic              alu_neg,
    input  logic              alu_zero,
    output logic              flag_n,
    output logic              flag_z,
    output logic              flag_c,
    output logic              flag_nz_we,
    output logic              flag_c_we
);

    typedef enum logic [2:0] {
        IDLE, READ, MODIFY, DUMMY_WR, WRITE, DONE
    } state_t;

    state_t              r_state;
    logic [2:0]          r_op;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_cin;
    logic [7:0]          r_operand;
    logic [7:0]          r_result;
    logic [7:0]          r_wdata;
    logic [3:0]          r_alu_op;
    logic                r_busy;
    logic                r_done;
    logic                r_err;
    logic                r_rd_req;
    logic                r_wr_req;
    logic                r_flag_n;
    logic                r_flag_z;
    logic                r_flag_c;
    logic                r_flag_c_we;
    logic                w_legal;

    function automatic logic [3:0] f_alu_code(input logic [2:0] i_op);
        case (i_op)
            3'd0:    f_alu_code = 4'b0101;
            3'd1:    f_alu_code = 4'b0110;
            3'd2:    f_alu_code = 4'b0111;
            3'd3:    f_alu_code = 4'b1000;
            3'd4:    f_alu_code = 4'b1001;
            3'd5:    f_alu_code = 4'b1010;
            default: f_alu_code = 4'b0000;
        endcase
    endfunction

    assign w_legal = (op <= 3'd5);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_op        <= 3'd0;
            r_addr      <= '0;
            r_cin       <= 1'b0;
            r_operand   <= 8'h00;
            r_result    <= 8'h00;
            r_wdata     <= 8'h00;
            r_alu_op    <= 4'b0000;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_rd_req    <= 1'b0;
            r_wr_req    <= 1'b0;
            r_flag_n    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_flag_c    <= 1'b0;
            r_flag_c_we <= 1'b0;
        end else begin
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_flag_c_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && w_legal) begin
                        r_addr   <= addr;
                        r_op     <= op;
                        r_cin    <= carry_in;
                        r_alu_op <= f_alu_code(op);
                        r_busy   <= 1'b1;
                        r_rd_req <= 1'b1;
                        r_state  <= READ;
                    end else if (start) begin
                        r_err <= 1'b1;
                    end
                end
                READ: begin
                    if (mem_rd_ack) begin
                        r_operand <= mem_rdata;
                        r_rd_req  <= 1'b0;
                        r_state   <= MODIFY;
                    end
                end
                MODIFY: begin
                    r_result <= alu_result;
                    r_flag_n <= alu_neg;
                    r_flag_z <= alu_zero;
                    r_flag_c <= alu_carry;
                    r_wr_req <= 1'b1;
                    if (DUMMY_WRITE != 0) begin
                        r_wdata <= r_operand;
                        r_state <= DUMMY_WR;
                    end else begin
                        r_wdata <= alu_result;
                        r_state <= WRITE;
                    end
                end
                DUMMY_WR: begin
                    // Request stays high; only the data switches to the result.
                    if (mem_wr_ack) begin
                        r_wdata <= r_result;
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    if (mem_wr_ack) begin
                        r_wr_req    <= 1'b0;
                        r_done      <= 1'b1;
                        r_flag_c_we <= ~r_op[2];
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_busy   <= 1'b0;
                    r_alu_op <= 4'b0000;
                    r_state  <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign mem_addr   = r_addr;
    assign mem_rd_req = r_rd_req;
    assign mem_wr_req = r_wr_req;
    assign mem_wdata  = r_wdata;
    assign alu_a      = r_operand;
    assign alu_b      = 8'h00;
    assign alu_op     = r_alu_op;
    assign alu_cin    = r_cin;
    assign flag_n     = r_flag_n;
    assign flag_z     = r_flag_z;
    assign flag_c     = r_flag_c;
    assign flag_nz_we = r_done;
    assign flag_c_we  = r_flag_c_we;

endmodule
